// File: rtl/seg_scan_reader.sv
// Receive side of a multiplexed 7-segment display link. It debounces each
// (seg, dig_sel) pair, decodes the digit, and assembles 4-digit BCD frames.
module seg_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_sel,
    output logic        dig_stb,
    output logic [1:0]  dig_idx,
    output logic [3:0]  dig_val,
    output logic [15:0] bcd,
    output logic        frame_valid,
    output logic        frame_err
);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_DONE} state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    state_t      state_q;
    logic [6:0]  seg_q;
    logic [3:0]  sel_q;
    logic [7:0]  cnt_q;
    logic [15:0] slots_q;
    logic [3:0]  mask_q;
    logic        err_q;
    logic        dig_stb_q;
    logic [1:0]  dig_idx_q;
    logic [3:0]  dig_val_q;
    logic [15:0] bcd_q;
    logic        frame_valid_q;
    logic        frame_err_q;

    logic        pair_onehot;
    logic        pair_same;
    logic        accept;
    logic [1:0]  new_idx;
    logic [3:0]  new_val;
    logic        new_inv;
    logic [3:0]  mask_d;
    logic [15:0] slots_d;
    logic        frame_done;

    // Returns {invalid, value}; unknown segment patterns decode to F.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1111110: decode_seg = 5'h00;
            7'b0110000: decode_seg = 5'h01;
            7'b1101101: decode_seg = 5'h02;
            7'b1111001: decode_seg = 5'h03;
            7'b0110011: decode_seg = 5'h04;
            7'b1011011: decode_seg = 5'h05;
            7'b1011111: decode_seg = 5'h06;
            7'b1110000: decode_seg = 5'h07;
            7'b1111111: decode_seg = 5'h08;
            7'b1111011: decode_seg = 5'h09;
            default:    decode_seg = 5'h1F;
        endcase
    endfunction

    function automatic logic [1:0] sel_to_idx(input logic [3:0] sel);
        case (sel)
            4'b0010: sel_to_idx = 2'd1;
            4'b0100: sel_to_idx = 2'd2;
            4'b1000: sel_to_idx = 2'd3;
            default: sel_to_idx = 2'd0;
        endcase
    endfunction

    always_comb begin
        pair_onehot = $onehot(dig_sel);
        pair_same   = (seg == seg_q) && (dig_sel == sel_q);
        accept      = (state_q == S_COUNT) && pair_onehot && pair_same &&
                      ((cnt_q + 8'd1) == CNT_MAX);
        new_idx     = sel_to_idx(dig_sel);
        {new_inv, new_val} = decode_seg(seg);
        mask_d      = mask_q | (4'b0001 << new_idx);
        slots_d     = slots_q;
        slots_d[{new_idx, 2'b00} +: 4] = new_val;
        frame_done  = accept && (mask_d == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_WAIT;
            seg_q         <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            slots_q       <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            dig_stb_q     <= 1'b0;
            dig_idx_q     <= '0;
            dig_val_q     <= '0;
            bcd_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            dig_stb_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            seg_q         <= seg;
            sel_q         <= dig_sel;

            if (!pair_onehot) begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        state_q <= S_COUNT;
                        cnt_q   <= 8'd1;
                    end
                    S_COUNT: begin
                        if (!pair_same) begin
                            cnt_q <= 8'd1;
                        end else if (accept) begin
                            state_q <= S_DONE;
                            cnt_q   <= CNT_MAX;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_DONE: begin
                        // Counter stays saturated for as long as the pair is held.
                        if (!pair_same) begin
                            state_q <= S_COUNT;
                            cnt_q   <= 8'd1;
                        end
                    end
                    default: begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                endcase
            end

            if (accept) begin
                dig_stb_q <= 1'b1;
                dig_idx_q <= new_idx;
                dig_val_q <= new_val;
                slots_q   <= slots_d;
                if (frame_done) begin
                    bcd_q         <= slots_d;
                    frame_valid_q <= 1'b1;
                    frame_err_q   <= err_q | new_inv;
                    mask_q        <= '0;
                    err_q         <= 1'b0;
                end else begin
                    mask_q <= mask_d;
                    err_q  <= err_q | new_inv;
                end
            end
        end
    end

    assign dig_stb     = dig_stb_q;
    assign dig_idx     = dig_idx_q;
    assign dig_val     = dig_val_q;
    assign bcd         = bcd_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed scenarios plus randomized traffic checked
// against a run-length based reference model.
module tb_seg_scan_reader;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        dig_stb;
    logic [1:0]  dig_idx;
    logic [3:0]  dig_val;
    logic [15:0] bcd;
    logic        frame_valid;
    logic        frame_err;

    seg_scan_reader #(.STABLE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
        .dig_stb(dig_stb), .dig_idx(dig_idx), .dig_val(dig_val),
        .bcd(bcd), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};

    int checks = 0;
    int errors = 0;

    // reference model state
    int         run;
    logic [6:0] pseg;
    logic [3:0] psel;
    logic [3:0] slot [4];
    bit         seen [4];
    bit         facc;
    logic       m_stb, m_fv, m_ferr;
    logic [1:0] m_idx;
    logic [3:0] m_val;
    logic [15:0] m_bcd;

    // observation tallies
    int         n_stb, n_fv, step_no, last_stb_step, last_fv_step;
    logic [3:0] obs_val [4];

    task automatic model_edge(input logic [6:0] s, input logic [3:0] d, input logic r);
        int idx;
        logic [3:0] val;
        bit inv;
        if (r) begin
            run = 0; pseg = '0; psel = '0; facc = 0;
            for (int i = 0; i < 4; i++) begin slot[i] = '0; seen[i] = 0; end
            m_stb = 0; m_fv = 0; m_ferr = 0; m_idx = '0; m_val = '0; m_bcd = '0;
            return;
        end
        m_stb = 0; m_fv = 0;
        if ($countones(d) != 1) run = 0;
        else if (run > 0 && s == pseg && d == psel) run++;
        else run = 1;
        pseg = s; psel = d;
        if (run == N) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (d[i]) idx = i;
            val = 4'hF; inv = 1;
            for (int k = 0; k < 10; k++) if (PAT[k] == s) begin val = 4'(k); inv = 0; end
            m_stb = 1; m_idx = 2'(idx); m_val = val;
            slot[idx] = val; seen[idx] = 1; facc = facc | inv;
            if (seen[0] && seen[1] && seen[2] && seen[3]) begin
                m_bcd = {slot[3], slot[2], slot[1], slot[0]};
                m_fv = 1; m_ferr = facc; facc = 0;
                for (int i = 0; i < 4; i++) seen[i] = 0;
            end
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [3:0] d, input logic r);
        @(negedge clk);
        seg = s; dig_sel = d; rst = r;
        @(posedge clk);
        model_edge(s, d, r);
        #1;
        step_no++;
        if (dig_stb === 1'b1) begin
            n_stb++; last_stb_step = step_no; obs_val[dig_idx] = dig_val;
        end
        if (frame_valid === 1'b1) begin n_fv++; last_fv_step = step_no; end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(s, d, 1'b0);
    endtask

    task automatic do_reset();
        step(7'h00, 4'b0000, 1'b1);
        step(7'h00, 4'b0000, 1'b1);
        n_stb = 0; n_fv = 0;
        for (int i = 0; i < 4; i++) obs_val[i] = '0;
    endtask

    task automatic send_frame(input int v0, input int v1, input int v2, input int v3);
        int v [4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            hold(PAT[v[i]], 4'(1 << i), 6);
            hold(7'h00, 4'b0000, 1);
        end
    endtask

    task automatic test_reset();
        step(PAT[5], 4'b0100, 1'b1);
        step(PAT[5], 4'b0100, 1'b1);
        checks++;
        if ({dig_stb, dig_idx, dig_val, bcd, frame_valid, frame_err} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stb=%b idx=%0d val=%h bcd=%h fv=%b ferr=%b, want all 0",
                     dig_stb, dig_idx, dig_val, bcd, frame_valid, frame_err);
        end
        n_stb = 0;
        // pair held across reset: first edge with rst=0 is E1
        hold(PAT[5], 4'b0100, 3);
        checks++;
        if (n_stb != 0) begin errors++; $display("FAIL reset_early_stb: got %0d strobes, want 0", n_stb); end
        hold(PAT[5], 4'b0100, 1);
        checks++;
        if (dig_stb !== 1'b1 || dig_idx !== 2'd2 || dig_val !== 4'd5) begin
            errors++;
            $display("FAIL reset_e4_stb: got stb=%b idx=%0d val=%h, want 1/2/5", dig_stb, dig_idx, dig_val);
        end
        hold(PAT[5], 4'b0100, 1);
        checks++;
        if (dig_stb !== 1'b0) begin errors++; $display("FAIL reset_stb_pulse: got %b, want 0", dig_stb); end
        // reset mid-dwell discards partial stability
        do_reset();
        hold(PAT[7], 4'b0001, 2);
        step(PAT[7], 4'b0001, 1'b1);
        hold(PAT[7], 4'b0001, 3);
        checks++;
        if (n_stb != 0) begin errors++; $display("FAIL reset_middwell: got %0d strobes, want 0", n_stb); end
        hold(PAT[7], 4'b0001, 1);
        checks++;
        if (dig_stb !== 1'b1) begin errors++; $display("FAIL reset_middwell_e4: got %b, want 1", dig_stb); end
    endtask

    task automatic test_frame_basic();
        do_reset();
        send_frame(1, 2, 3, 4);
        checks++;
        if (n_stb != 4 || n_fv != 1) begin
            errors++;
            $display("FAIL basic_counts: got stb=%0d fv=%0d, want 4/1", n_stb, n_fv);
        end
        checks++;
        if (bcd !== 16'h4321 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_bcd: got bcd=%h ferr=%b, want 4321/0", bcd, frame_err);
        end
        checks++;
        if (last_fv_step != last_stb_step) begin
            errors++;
            $display("FAIL basic_fv_align: fv at step %0d, last stb at step %0d, want equal", last_fv_step, last_stb_step);
        end
    endtask

    task automatic test_short_dwell();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hold(PAT[i + 1], 4'(1 << i), 3);
            hold(7'h00, 4'b0000, 1);
        end
        checks++;
        if (n_stb != 0 || n_fv != 0) begin
            errors++;
            $display("FAIL dwell3: got stb=%0d fv=%0d, want 0/0", n_stb, n_fv);
        end
        hold(PAT[5], 4'b0001, 3);
        checks++;
        if (dig_stb !== 1'b0) begin errors++; $display("FAIL dwell4_early: got %b, want 0", dig_stb); end
        hold(PAT[5], 4'b0001, 1);
        checks++;
        if (dig_stb !== 1'b1 || dig_idx !== 2'd0 || dig_val !== 4'd5) begin
            errors++;
            $display("FAIL dwell4_stb: got stb=%b idx=%0d val=%h, want 1/0/5", dig_stb, dig_idx, dig_val);
        end
    endtask

    task automatic test_invalid_digit();
        do_reset();
        hold(PAT[9], 4'b0001, 6); hold(7'h00, 4'b0000, 1);
        hold(PAT[8], 4'b0010, 6); hold(7'h00, 4'b0000, 1);
        hold(7'b1000000, 4'b0100, 6); hold(7'h00, 4'b0000, 1);
        hold(PAT[7], 4'b1000, 6); hold(7'h00, 4'b0000, 3);
        checks++;
        if (obs_val[2] !== 4'hF) begin errors++; $display("FAIL invalid_val: got %h, want F", obs_val[2]); end
        checks++;
        if (bcd !== 16'h7F89 || frame_err !== 1'b1 || n_fv != 1) begin
            errors++;
            $display("FAIL invalid_frame: got bcd=%h ferr=%b fv=%0d, want 7F89/1/1", bcd, frame_err, n_fv);
        end
        // error flag holds through the next partial frame, then clears on a clean frame
        hold(PAT[1], 4'b0001, 6);
        checks++;
        if (frame_err !== 1'b1 || bcd !== 16'h7F89) begin
            errors++;
            $display("FAIL invalid_hold: got bcd=%h ferr=%b, want 7F89/1", bcd, frame_err);
        end
        send_frame(0, 6, 9, 2);
        checks++;
        if (frame_err !== 1'b0 || bcd !== 16'h2960) begin
            errors++;
            $display("FAIL invalid_clear: got bcd=%h ferr=%b, want 2960/0", bcd, frame_err);
        end
    endtask

    task automatic test_long_dwell();
        do_reset();
        hold(PAT[6], 4'b0010, 100);
        checks++;
        if (n_stb != 1) begin errors++; $display("FAIL long_single: got %0d strobes, want 1", n_stb); end
        step(PAT[8], 4'b0010, 1'b0);
        hold(PAT[6], 4'b0010, 3);
        checks++;
        if (n_stb != 1) begin errors++; $display("FAIL glitch_early: got %0d strobes, want 1", n_stb); end
        hold(PAT[6], 4'b0010, 1);
        checks++;
        if (dig_stb !== 1'b1 || dig_idx !== 2'd1 || dig_val !== 4'd6) begin
            errors++;
            $display("FAIL glitch_restrobe: got stb=%b idx=%0d val=%h, want 1/1/6", dig_stb, dig_idx, dig_val);
        end
        hold(7'h00, 4'b0000, 1);
        hold(PAT[3], 4'b0010, 6); hold(7'h00, 4'b0000, 1);
        hold(PAT[0], 4'b0001, 6); hold(7'h00, 4'b0000, 1);
        hold(PAT[2], 4'b0100, 6); hold(7'h00, 4'b0000, 1);
        checks++;
        if (n_fv != 0 || bcd !== 16'h0000) begin
            errors++;
            $display("FAIL overwrite_mask: got fv=%0d bcd=%h, want 0/0000", n_fv, bcd);
        end
        hold(PAT[5], 4'b1000, 6); hold(7'h00, 4'b0000, 1);
        checks++;
        if (n_fv != 1 || bcd !== 16'h5230) begin
            errors++;
            $display("FAIL overwrite_frame: got fv=%0d bcd=%h, want 1/5230", n_fv, bcd);
        end
    endtask

    task automatic test_non_onehot();
        do_reset();
        hold(PAT[3], 4'b0110, 10);
        hold(PAT[3], 4'b0000, 5);
        checks++;
        if (n_stb != 0) begin errors++; $display("FAIL nonehot: got %0d strobes, want 0", n_stb); end
        // from the WAIT state a one-hot pair needs the full dwell again
        hold(PAT[3], 4'b0010, 3);
        checks++;
        if (n_stb != 0) begin errors++; $display("FAIL nonehot_wait: got %0d strobes, want 0", n_stb); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hold(PAT[i + 1], 4'(1 << i), 6);
            hold(7'h00, 4'b0000, 1);
        end
        step(7'h00, 4'b0000, 1'b1);
        hold(PAT[4], 4'b1000, 6);
        hold(7'h00, 4'b0000, 2);
        checks++;
        if (n_stb != 4 || n_fv != 0 || bcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_partial_frame: got stb=%0d fv=%0d bcd=%h, want 4/0/0000", n_stb, n_fv, bcd);
        end
    endtask

    task automatic test_random();
        logic [6:0] s;
        logic [3:0] d;
        int dwell;
        bit r;
        do_reset();
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 99) < 85) d = 4'(1 << $urandom_range(0, 3));
            else begin
                d = 4'($urandom_range(0, 15));
                while ($countones(d) == 1) d = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 80) s = PAT[$urandom_range(0, 9)];
            else s = 7'($urandom);
            dwell = $urandom_range(1, 7);
            for (int c = 0; c < dwell; c++) begin
                r = ($urandom_range(0, 199) == 0);
                step(s, d, r);
                checks++;
                if (dig_stb !== m_stb || frame_valid !== m_fv || frame_err !== m_ferr ||
                    bcd !== m_bcd || (m_stb && (dig_idx !== m_idx || dig_val !== m_val))) begin
                    errors++;
                    $display("FAIL random_t%0d: got stb=%b idx=%0d val=%h fv=%b ferr=%b bcd=%h, want %b/%0d/%h/%b/%b/%h",
                             t, dig_stb, dig_idx, dig_val, frame_valid, frame_err, bcd,
                             m_stb, m_idx, m_val, m_fv, m_ferr, m_bcd);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; seg = '0; dig_sel = '0;
        run = 0; step_no = 0; n_stb = 0; n_fv = 0; last_stb_step = 0; last_fv_step = 0;
        model_edge(7'h00, 4'b0000, 1'b1);
        test_reset();
        test_frame_basic();
        test_short_dwell();
        test_invalid_digit();
        test_long_dwell();
        test_non_onehot();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required to accept a digit.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 seg  input  7  segment lines {a,b,c,d,e,f,g}, a = bit 6, active-high lit.
REQ-005 dig_sel  input  4  digit select; one-hot active-high, bit i selects display digit i.
REQ-006 dig_stb  output  1  one-cycle pulse: a digit was accepted.
REQ-007 dig_idx  output  2  index of accepted digit; valid while dig_stb = 1.
REQ-008 dig_val  output  4  decoded value of accepted digit; valid while dig_stb = 1.
REQ-009 bcd  output  16  last completed frame; digit i at bcd[4i+3:4i].
REQ-010 frame_valid  output  1  one-cycle pulse: bcd updated with a complete frame.
REQ-011 frame_err  output  1  high with frame_valid when any digit in that frame was invalid; held until next frame_valid.

Function
REQ-012 The block SHALL be the receive side of the multiplexed 7-segment display interface: it samples seg/dig_sel and recovers 4 BCD digits.
REQ-013 Decode table (abcdefg -> value) SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; every other pattern -> 4'hF, marked invalid.
REQ-014 A sample pair is (seg, dig_sel) taken at a rising edge; a pair with dig_sel not one-hot (0000 or multiple bits) SHALL be ignored and SHALL return the FSM to WAIT.
REQ-015 FSM states SHALL be WAIT, COUNT, DONE.
REQ-016 WAIT -> COUNT on a one-hot pair; stability counter loaded to 1.
REQ-017 COUNT: pair equal to previous -> counter +1; pair different but one-hot -> counter reloaded to 1 (stay COUNT); non-one-hot -> WAIT.
REQ-018 COUNT -> DONE when counter reaches STABLE_CYCLES; the digit SHALL be accepted exactly once at that transition.
REQ-019 DONE: equal pair -> stay, no further acceptance; different one-hot pair -> COUNT with counter 1; non-one-hot -> WAIT.
REQ-020 Latency: pair first sampled at edge E1 and held; dig_stb SHALL be high in the cycle following edge E(STABLE_CYCLES), low after the next edge.
REQ-021 On acceptance the block SHALL store dig_val into digit slot dig_idx, set mask bit dig_idx, and OR invalid into a frame error flag.
REQ-022 Re-acceptance of a digit already in the mask SHALL overwrite its slot; the mask is unchanged.
REQ-023 When an acceptance completes the mask (1111), in the same cycle as that dig_stb: bcd SHALL load all four slots (new digit included), frame_valid pulses, frame_err loads the frame error flag; mask and frame error flag clear.
REQ-024 bcd and frame_err SHALL change only on frame_valid or reset.
REQ-025 Counter SHALL saturate at STABLE_CYCLES; no wrap regardless of dwell length.

Reset
REQ-026 While rst = 1 at an edge: dig_stb, dig_idx, dig_val, bcd, frame_valid, frame_err = 0; mask, slots, error flag, counter = 0; FSM = WAIT.
REQ-027 Reset mid-dwell SHALL discard partial stability and partial frame; a pair held across reset counts from the first edge with rst = 0 as E1.

Verification
REQ-028 STABLE_CYCLES=4; drive digits 0..3 = 1,2,3,4 (dwell 6 cycles each, 0000 gap 1 cycle) -> four dig_stb, frame_valid once, bcd = 16'h4321, frame_err = 0.
REQ-029 Dwell of exactly 3 cycles per digit -> no dig_stb, no frame_valid; dwell 4 -> dig_stb in cycle after 4th sample edge.
REQ-030 Digit 2 seg = 1000000 in otherwise valid frame (9,8,x,7) -> that dig_val = F, bcd = 16'h7F89, frame_err = 1.
REQ-031 Dwell 100 cycles on one digit -> single dig_stb; seg glitch for 1 cycle mid-dwell -> counter restarts, second dig_stb after 4 further stable cycles (overwrite, mask unchanged).
REQ-032 dig_sel = 0110 for 10 cycles -> no acceptance, FSM WAIT; assert rst after 3 of 4 digits accepted, then send one digit -> no frame_valid, bcd stays 0.
